// File: rtl/bt_pkg.sv
// Shared types and helpers for the Bluetooth command path.
// Contents: default header byte, parser FSM state type, command payload
// struct and the packet checksum function.
package bt_pkg;

  localparam logic [7:0] BT_HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_CODE = 3'd1,
    ST_GET_ARG  = 3'd2,
    ST_GET_CHK  = 3'd3,
    ST_DELIVER  = 3'd4
  } bt_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] arg;
  } bt_cmd_t;

  // Packet check byte: XOR of command and argument.
  function automatic logic [7:0] bt_chk(input logic [7:0] code, input logic [7:0] arg);
    return code ^ arg;
  endfunction

endpackage

// File: rtl/bt_edge_sync.sv
// Two-flop synchroniser for an asynchronous level flag plus rising-edge
// detector producing a registered one-cycle event.
// Ports:
//   clk_in     - destination clock
//   reset      - synchronous, active-high
//   async_flag - flag from another clock domain
//   byte_evt   - one-cycle pulse on each synchronised rising edge
module bt_edge_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic async_flag,
  output logic byte_evt
);

  logic sync1;
  logic sync2;

  // byte_evt and sync2 both form the second stage behind sync1, so the
  // event lands in the same cycle the synchronised level rises.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      byte_evt <= 1'b0;
    end else begin
      sync1    <= async_flag;
      sync2    <= sync1;
      byte_evt <= sync1 & ~sync2;
    end
  end

endmodule

// File: rtl/bt_cmd_parser.sv
// Frames bytes from the Bluetooth UART receiver into command packets
// (HEADER, CODE, ARG[, CHK]), validates them and offers one command at a
// time to the consumer over a valid/ready handshake.
// Build option: define BT_CHECKSUM_EN for 4-byte packets with a CHK byte
// (CODE ^ ARG); otherwise packets are 3 bytes and err_chk is tied low.
// Ports:
//   clk_in, reset          - system clock, synchronous active-high reset
//   rx_avail, rx_data      - receiver byte flag (async) and byte
//   cmd_ready              - consumer accepts the pending command
//   cmd_valid, cmd_code,
//   cmd_arg                - pending command
//   err_chk, err_timeout,
//   err_overrun            - one-cycle error pulses
module bt_cmd_parser
  import bt_pkg::*;
#(
  parameter logic [7:0]  HEADER         = BT_HEADER_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx_avail,
  input  logic [7:0] rx_data,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       err_chk,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             byte_evt;
  bt_state_t        state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  bt_cmd_t          pend_q, pend_n;
  bt_cmd_t          out_n;
  logic             valid_n;
  logic             err_to_n;
  logic             err_ov_n;
  logic             counting;
  logic             timeout_c;
`ifdef BT_CHECKSUM_EN
  logic             err_chk_n;
`endif

  bt_edge_sync u_sync (
    .clk_in     (clk_in),
    .reset      (reset),
    .async_flag (rx_avail),
    .byte_evt   (byte_evt)
  );

  assign counting  = (state_q == ST_GET_CODE) || (state_q == ST_GET_ARG) ||
                     (state_q == ST_GET_CHK);
  // Limit reached on this edge; a coincident byte event takes priority.
  assign timeout_c = counting && !byte_evt && (cnt_q == CNT_LAST);

  // Next-state, counter and output computation.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    pend_n   = pend_q;
    out_n    = {cmd_code, cmd_arg};
    valid_n  = cmd_valid & ~cmd_ready;
    err_to_n = 1'b0;
    err_ov_n = 1'b0;
`ifdef BT_CHECKSUM_EN
    err_chk_n = 1'b0;
`endif

    if (byte_evt || state_q == ST_IDLE) begin
      cnt_n = '0;
    end else if (counting && cnt_q != CNT_MAX) begin
      cnt_n = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (byte_evt && rx_data == HEADER) state_n = ST_GET_CODE;
      end
      ST_GET_CODE: begin
        if (byte_evt) begin
          pend_n.code = rx_data;
          state_n     = ST_GET_ARG;
        end else if (timeout_c) begin
          err_to_n = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      ST_GET_ARG: begin
        if (byte_evt) begin
          pend_n.arg = rx_data;
`ifdef BT_CHECKSUM_EN
          state_n    = ST_GET_CHK;
`else
          state_n    = ST_DELIVER;
`endif
        end else if (timeout_c) begin
          err_to_n = 1'b1;
          state_n  = ST_IDLE;
        end
      end
`ifdef BT_CHECKSUM_EN
      ST_GET_CHK: begin
        if (byte_evt) begin
          if (rx_data == bt_chk(pend_q.code, pend_q.arg)) begin
            state_n = ST_DELIVER;
          end else begin
            err_chk_n = 1'b1;
            state_n   = ST_IDLE;
          end
        end else if (timeout_c) begin
          err_to_n = 1'b1;
          state_n  = ST_IDLE;
        end
      end
`endif
      ST_DELIVER: begin
        state_n = ST_IDLE;
        // A command still pending and not being taken this cycle wins.
        if (cmd_valid && !cmd_ready) begin
          err_ov_n = 1'b1;
        end else begin
          valid_n = 1'b1;
          out_n   = pend_q;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= 8'h00;
      cmd_arg     <= 8'h00;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
`ifdef BT_CHECKSUM_EN
      err_chk     <= 1'b0;
`endif
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      pend_q      <= pend_n;
      cmd_valid   <= valid_n;
      cmd_code    <= out_n.code;
      cmd_arg     <= out_n.arg;
      err_timeout <= err_to_n;
      err_overrun <= err_ov_n;
`ifdef BT_CHECKSUM_EN
      err_chk     <= err_chk_n;
`endif
    end
  end

`ifndef BT_CHECKSUM_EN
  assign err_chk = 1'b0;
`endif

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Self-checking bench for bt_cmd_parser (works with or without
// BT_CHECKSUM_EN). Expected commands are queued when a packet is sent and
// compared by a monitor when the consumer accepts them.
module tb_bt_cmd_parser;

  localparam int unsigned TO  = 100;
  localparam logic [7:0]  HDR = 8'hA5;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       rx_avail;
  logic [7:0] rx_data;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       err_chk;
  logic       err_timeout;
  logic       err_overrun;

  always #5 clk_in = ~clk_in;

  bt_cmd_parser #(.HEADER(HDR), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .rx_avail    (rx_avail),
    .rx_data     (rx_data),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_arg     (cmd_arg),
    .err_chk     (err_chk),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] arg;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_err_chk = 0, n_err_to = 0, n_err_ov = 0, valid_cycles = 0;
  int   last_chk_cyc = -1, last_to_cyc = -1, last_ov_cyc = -1, first_valid_cyc = -1;
  logic prev_valid = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: records error pulses / valid timing and scores accepted commands.
  always @(negedge clk_in) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (cmd_valid) valid_cycles++;
      if (cmd_valid && !prev_valid) first_valid_cyc = cyc;
      prev_valid = cmd_valid;
      if (err_chk)     begin n_err_chk++; last_chk_cyc = cyc; end
      if (err_timeout) begin n_err_to++;  last_to_cyc  = cyc; end
      if (err_overrun) begin n_err_ov++;  last_ov_cyc  = cyc; end
      if (cmd_valid && cmd_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL cmd_unexpected: got code=%h arg=%h, none expected", cmd_code, cmd_arg);
        end else begin
          e = exp_q.pop_front();
          if ({cmd_code, cmd_arg} !== {e.code, e.arg})
            $display("FAIL cmd_payload: got code=%h arg=%h want code=%h arg=%h",
                     cmd_code, cmd_arg, e.code, e.arg);
          else
            n_pass++;
        end
      end
    end
  end

  // One byte: flag high 3 cycles, low 3 cycles. evt = cycle of the byte event.
  task automatic send_byte(input logic [7:0] b, output int evt);
    @(posedge clk_in); #1;
    rx_data  = b;
    rx_avail = 1'b1;
    evt      = cyc + 2;
    repeat (3) @(posedge clk_in);
    #1 rx_avail = 1'b0;
    repeat (3) @(posedge clk_in);
  endtask

  task automatic send_pkt(input logic [7:0] code, input logic [7:0] arg, output int evt);
    send_byte(HDR, evt);
    send_byte(code, evt);
    send_byte(arg, evt);
`ifdef BT_CHECKSUM_EN
    send_byte(code ^ arg, evt);
`endif
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_avail = 1'b0; rx_data = 8'h00; cmd_ready = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if ({cmd_valid, err_chk, err_timeout, err_overrun} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {cmd_valid, err_chk, err_timeout, err_overrun});
    else n_pass++;
    n_checks++;
    if ({cmd_code, cmd_arg} !== 16'h0000)
      $display("FAIL reset_cmd: got %h want 0000", {cmd_code, cmd_arg});
    else n_pass++;
  endtask

  task automatic test_good_packet;
    int evt;
    int v0 = valid_cycles;
    int errs0 = n_err_chk + n_err_to + n_err_ov;
    cmd_ready = 1'b1;
    exp_q.push_back({8'h10, 8'h22});
    send_pkt(8'h10, 8'h22, evt);
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    n_checks++;
    if (first_valid_cyc !== evt + 2)
      $display("FAIL good_latency: got cycle %0d want %0d", first_valid_cyc, evt + 2);
    else n_pass++;
    n_checks++;
    if (valid_cycles - v0 !== 1)
      $display("FAIL good_valid_len: got %0d want 1", valid_cycles - v0);
    else n_pass++;
    n_checks++;
    if (n_err_chk + n_err_to + n_err_ov !== errs0)
      $display("FAIL good_no_err: got %0d errors want 0", n_err_chk + n_err_to + n_err_ov - errs0);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0)
      $display("FAIL good_delivered: got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask

`ifdef BT_CHECKSUM_EN
  task automatic test_bad_chk;
    int evt;
    int c0 = n_err_chk;
    int v0 = valid_cycles;
    send_byte(HDR, evt);
    send_byte(8'h10, evt);
    send_byte(8'h22, evt);
    send_byte(8'h33, evt);
    @(negedge clk_in);
    n_checks++;
    if (n_err_chk - c0 !== 1)
      $display("FAIL chk_count: got %0d pulses want 1", n_err_chk - c0);
    else n_pass++;
    n_checks++;
    if (last_chk_cyc !== evt + 1)
      $display("FAIL chk_timing: got cycle %0d want %0d", last_chk_cyc, evt + 1);
    else n_pass++;
    n_checks++;
    if (valid_cycles !== v0)
      $display("FAIL chk_no_valid: got %0d valid cycles want 0", valid_cycles - v0);
    else n_pass++;
    exp_q.push_back({8'h44, 8'h55});
    send_pkt(8'h44, 8'h55, evt);
    repeat (3) @(posedge clk_in);
    n_checks++;
    if (exp_q.size() !== 0)
      $display("FAIL chk_recover: got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask
`endif

  task automatic test_timeout;
    int evt;
    int t0 = n_err_to;
    send_byte(HDR, evt);
    send_byte(8'h10, evt);
    repeat (TO + 20) @(posedge clk_in);
    @(negedge clk_in);
    n_checks++;
    if (n_err_to - t0 !== 1)
      $display("FAIL timeout_count: got %0d pulses want 1", n_err_to - t0);
    else n_pass++;
    // Counter is 0 in the cycle after the event and reaches TO, TO cycles later.
    n_checks++;
    if (last_to_cyc !== evt + int'(TO) + 1)
      $display("FAIL timeout_timing: got cycle %0d want %0d", last_to_cyc, evt + int'(TO) + 1);
    else n_pass++;
    exp_q.push_back({8'h01, 8'h02});
    send_pkt(8'h01, 8'h02, evt);
    repeat (3) @(posedge clk_in);
    n_checks++;
    if (exp_q.size() !== 0)
      $display("FAIL timeout_recover: got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_overrun;
    int e1, e2;
    int o0 = n_err_ov;
    cmd_ready = 1'b0;
    exp_q.push_back({8'h10, 8'h22});
    send_pkt(8'h10, 8'h22, e1);
    send_pkt(8'h33, 8'h44, e2);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    n_checks++;
    if (first_valid_cyc !== e1 + 2)
      $display("FAIL ovr_first_latency: got cycle %0d want %0d", first_valid_cyc, e1 + 2);
    else n_pass++;
    n_checks++;
    if (n_err_ov - o0 !== 1)
      $display("FAIL ovr_count: got %0d pulses want 1", n_err_ov - o0);
    else n_pass++;
    n_checks++;
    if (last_ov_cyc !== e2 + 2)
      $display("FAIL ovr_timing: got cycle %0d want %0d", last_ov_cyc, e2 + 2);
    else n_pass++;
    n_checks++;
    if ({cmd_valid, cmd_code, cmd_arg} !== {1'b1, 8'h10, 8'h22})
      $display("FAIL ovr_held: got v=%b %h/%h want v=1 10/22", cmd_valid, cmd_code, cmd_arg);
    else n_pass++;
    @(posedge clk_in); #1 cmd_ready = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    n_checks++;
    if (cmd_valid !== 1'b0)
      $display("FAIL ovr_clear: got valid=%b want 0", cmd_valid);
    else n_pass++;
  endtask

  task automatic test_junk;
    int evt;
    logic [7:0] seq [6];
    seq = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h07, 8'hA2};
    exp_q.push_back({8'hA5, 8'h07});
    for (int i = 0; i < 6; i++) send_byte(seq[i], evt);
    repeat (3) @(posedge clk_in);
    n_checks++;
    if (exp_q.size() !== 0)
      $display("FAIL junk_delivered: got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int evt;
    int v0;
    send_byte(HDR, evt);
    send_byte(8'h10, evt);
    @(posedge clk_in); #1 reset = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    n_checks++;
    if ({cmd_valid, err_chk, err_timeout, err_overrun, cmd_code, cmd_arg} !== 20'h0)
      $display("FAIL midreset_outputs: got v=%b e=%b%b%b %h/%h want all 0",
               cmd_valid, err_chk, err_timeout, err_overrun, cmd_code, cmd_arg);
    else n_pass++;
    #1 reset = 1'b0;
    v0 = valid_cycles;
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    n_checks++;
    if (valid_cycles !== v0)
      $display("FAIL midreset_no_valid: got %0d valid cycles want 0", valid_cycles - v0);
    else n_pass++;
    exp_q.push_back({8'h5A, 8'h3C});
    send_pkt(8'h5A, 8'h3C, evt);
    repeat (3) @(posedge clk_in);
    n_checks++;
    if (exp_q.size() !== 0)
      $display("FAIL midreset_recover: got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_packet();
`ifdef BT_CHECKSUM_EN
    test_bad_chk();
`endif
    test_timeout();
    test_overrun();
    test_junk();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
